// File: rtl/pico_sequencer.sv
// pico_sequencer: four-stage instruction sequencer with operator handshake wait states.
// Define PICO_SEQ_SYNC_EN to pass Handshake through a two-flop synchroniser before use.
//
// state          | meaning
// ---------------+------------------------------------------------------------
// S_FETCH        | Addr presented to program memory
// S_DECODE       | latch WaitReq/Jump/JumpAddr of the fetched instruction
// S_WAIT_ASSERT  | hold PC until operator handshake is seen high
// S_EXEC         | single-cycle accumulator write enable
// S_WB           | single-cycle register-file write qualifier
// S_WAIT_RELEASE | hold PC until operator handshake is seen low again
module pico_sequencer #(
  parameter int ADDR_W    = 5,
  parameter int LAST_ADDR = 31
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              Handshake,
  input  logic              WaitReq,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] JumpAddr,
  output logic [ADDR_W-1:0] Addr,
  output logic [1:0]        Stage,
  output logic              FetchEn,
  output logic              ExecEn,
  output logic              WbEn,
  output logic              PCHold
);

  typedef enum logic [2:0] {
    S_FETCH        = 3'd0,
    S_DECODE       = 3'd1,
    S_EXEC         = 3'd2,
    S_WB           = 3'd3,
    S_WAIT_ASSERT  = 3'd4,
    S_WAIT_RELEASE = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic              wait_q, wait_d;
  logic              jump_q, jump_d;
  logic [ADDR_W-1:0] addr_next;
  logic              hs;

`ifdef PICO_SEQ_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], Handshake};

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign hs = sync_q[1];
`else
  assign hs = Handshake;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_FETCH;
      addr_q  <= '0;
      jaddr_q <= '0;
      wait_q  <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      jaddr_q <= jaddr_d;
      wait_q  <= wait_d;
      jump_q  <= jump_d;
    end
  end

  // A jump wins over the wrap, so a jump to the current address re-executes it.
  always_comb begin
    if (jump_q)              addr_next = jaddr_q;
    else if (addr_q == LAST) addr_next = '0;
    else                     addr_next = addr_q + ADDR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    jaddr_d = jaddr_q;
    wait_d  = wait_q;
    jump_d  = jump_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        wait_d  = WaitReq;
        jump_d  = Jump;
        jaddr_d = JumpAddr;
        state_d = WaitReq ? S_WAIT_ASSERT : S_EXEC;
      end
      S_WAIT_ASSERT: begin
        if (hs) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        if (wait_q) begin
          state_d = S_WAIT_RELEASE;
        end else begin
          state_d = S_FETCH;
          addr_d  = addr_next;
        end
      end
      S_WAIT_RELEASE: begin
        if (!hs) begin
          state_d = S_FETCH;
          addr_d  = addr_next;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    Stage   = 2'd0;
    FetchEn = 1'b0;
    ExecEn  = 1'b0;
    WbEn    = 1'b0;
    PCHold  = 1'b0;
    case (state_q)
      S_FETCH: FetchEn = 1'b1;
      S_DECODE: Stage = 2'd1;
      S_EXEC: begin
        Stage  = 2'd2;
        ExecEn = 1'b1;
      end
      S_WB: begin
        Stage = 2'd3;
        WbEn  = 1'b1;
      end
      S_WAIT_ASSERT, S_WAIT_RELEASE: begin
        Stage  = 2'd2;
        PCHold = 1'b1;
      end
      default: FetchEn = 1'b1;
    endcase
  end

  assign Addr = addr_q;

endmodule

// File: tb/tb_pico_sequencer.sv
// Self-checking bench for pico_sequencer: an instruction-level trace model predicts
// every output per cycle from the program, the handshake waveform and the sampling latency.
module tb_pico_sequencer;
  localparam int AW   = 5;
  localparam int LAST = 3;
  localparam int MAXC = 1024;
  localparam int VW   = AW + 6;
`ifdef PICO_SEQ_SYNC_EN
  localparam int HS_LAT = 2;
`else
  localparam int HS_LAT = 0;
`endif
  localparam logic [VW-1:0] RESET_VEC = VW'(8);

  logic          Clock = 1'b0;
  logic          nReset = 1'b1;
  logic          Handshake = 1'b0;
  logic          WaitReq = 1'b0;
  logic          Jump = 1'b0;
  logic [AW-1:0] JumpAddr = '0;
  logic [AW-1:0] Addr;
  logic [1:0]    Stage;
  logic          FetchEn, ExecEn, WbEn, PCHold;

  pico_sequencer #(.ADDR_W(AW), .LAST_ADDR(LAST)) dut (
    .Clock(Clock), .nReset(nReset), .Handshake(Handshake), .WaitReq(WaitReq),
    .Jump(Jump), .JumpAddr(JumpAddr), .Addr(Addr), .Stage(Stage),
    .FetchEn(FetchEn), .ExecEn(ExecEn), .WbEn(WbEn), .PCHold(PCHold)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  bit            h_arr[MAXC];
  bit            in_w[MAXC];
  bit            in_j[MAXC];
  logic [AW-1:0] in_ja[MAXC];
  logic [VW-1:0] exp_vec[MAXC];
  logic [VW-1:0] obs_vec[MAXC];
  bit            q_w[$];
  bit            q_j[$];
  logic [AW-1:0] q_ja[$];
  bit            rnd_mode;

  function automatic bit hs_at(input int c);
    return (c >= HS_LAT) ? h_arr[c - HS_LAT] : 1'b0;
  endfunction

  task automatic clear_prog();
    q_w.delete(); q_j.delete(); q_ja.delete();
    for (int k = 0; k < MAXC; k++) h_arr[k] = 1'b0;
  endtask

  task automatic add_ins(input bit w, input bit j, input logic [AW-1:0] ja);
    q_w.push_back(w); q_j.push_back(j); q_ja.push_back(ja);
  endtask

  // Vector layout: {Addr, Stage, FetchEn, ExecEn, WbEn, PCHold}. Outside DECODE the
  // decode inputs carry misleading values that must be ignored.
  task automatic put(input int c, input logic [AW-1:0] a, input logic [1:0] st,
                     input logic [3:0] en, input bit dec, input bit w, input bit j,
                     input logic [AW-1:0] ja);
    if (c < MAXC) begin
      exp_vec[c] = {a, st, en};
      if (dec) begin
        in_w[c] = w; in_j[c] = j; in_ja[c] = ja;
      end else if (rnd_mode) begin
        in_w[c] = 1'($urandom); in_j[c] = 1'($urandom); in_ja[c] = AW'($urandom);
      end else begin
        in_w[c] = !w; in_j[c] = !j; in_ja[c] = ja + AW'(2);
      end
    end
  endtask

  task automatic build(input int n);
    int c, i;
    logic [AW-1:0] a, ja;
    bit w, j, done;
    c = 0; i = 0; a = '0;
    while (c < n) begin
      w  = q_w[i % q_w.size()];
      j  = q_j[i % q_j.size()];
      ja = q_ja[i % q_ja.size()];
      put(c, a, 2'd0, 4'b1000, 1'b0, w, j, ja); c++;
      put(c, a, 2'd1, 4'b0000, 1'b1, w, j, ja); c++;
      if (w) begin
        done = 1'b0;
        while (!done && c < n) begin
          put(c, a, 2'd2, 4'b0001, 1'b0, w, j, ja);
          done = hs_at(c); c++;
        end
      end
      put(c, a, 2'd2, 4'b0100, 1'b0, w, j, ja); c++;
      put(c, a, 2'd3, 4'b0010, 1'b0, w, j, ja); c++;
      if (w) begin
        done = 1'b0;
        while (!done && c < n) begin
          put(c, a, 2'd2, 4'b0001, 1'b0, w, j, ja);
          done = !hs_at(c); c++;
        end
      end
      if (j)              a = ja;
      else if (a == LAST) a = '0;
      else                a = a + 1'b1;
      i++;
    end
  endtask

  task automatic do_reset();
    Handshake = 1'b0; WaitReq = 1'b0; Jump = 1'b0; JumpAddr = '0;
    @(negedge Clock); nReset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 nReset = 1'b1;
  endtask

  task automatic play(input int n);
    for (int k = 0; k < n; k++) begin
      Handshake = h_arr[k]; WaitReq = in_w[k]; Jump = in_j[k]; JumpAddr = in_ja[k];
      @(negedge Clock);
      obs_vec[k] = {Addr, Stage, FetchEn, ExecEn, WbEn, PCHold};
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic test_reset();
    nReset = 1'b1;
    #3 nReset = 1'b0;
    #1;
    checks++;
    if ({Addr, Stage, FetchEn, ExecEn, WbEn, PCHold} !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", {Addr, Stage, FetchEn, ExecEn, WbEn, PCHold}, RESET_VEC);
    end
    repeat (2) @(posedge Clock);
    #1 nReset = 1'b1;
    clear_prog(); add_ins(1'b0, 1'b0, '0); rnd_mode = 1'b0;
    build(3); play(3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL reset_release cycle %0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
      end
    end
  endtask

  task automatic test_sequence();
    logic [AW-1:0] want_addr[12];
    int n_exec;
    want_addr = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    do_reset();
    clear_prog(); add_ins(1'b0, 1'b0, AW'(5)); rnd_mode = 1'b0;
    build(12); play(12);
    n_exec = 0;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL seq_trace cycle %0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
      end
      checks++;
      if (obs_vec[k][VW-1:6] !== want_addr[k]) begin
        errors++;
        $display("FAIL seq_addr cycle %0d: got %0d expected %0d", k, obs_vec[k][VW-1:6], want_addr[k]);
      end
      if (obs_vec[k][2] === 1'b1) n_exec++;
    end
    checks++;
    if (n_exec != 3) begin
      errors++;
      $display("FAIL seq_exec_count: got %0d expected 3", n_exec);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    clear_prog(); add_ins(1'b0, 1'b0, AW'(1)); rnd_mode = 1'b0;
    build(24); play(24);
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL wrap_trace cycle %0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
      end
    end
    checks++;
    if (obs_vec[15][VW-1:6] !== AW'(3) || obs_vec[16][VW-1:6] !== AW'(0)) begin
      errors++;
      $display("FAIL wrap_edge: got %0d->%0d expected 3->0", obs_vec[15][VW-1:6], obs_vec[16][VW-1:6]);
    end
  endtask

  task automatic test_jump();
    do_reset();
    clear_prog();
    add_ins(1'b0, 1'b0, AW'(0));
    add_ins(1'b0, 1'b0, AW'(0));
    add_ins(1'b0, 1'b1, AW'(7));
    add_ins(1'b0, 1'b1, AW'(7));
    rnd_mode = 1'b0;
    build(28); play(28);
    for (int k = 0; k < 28; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL jump_trace cycle %0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
      end
    end
    checks++;
    if (obs_vec[12][VW-1:6] !== AW'(7)) begin
      errors++;
      $display("FAIL jump_target: got %0d expected 7", obs_vec[12][VW-1:6]);
    end
    checks++;
    if (obs_vec[16][VW-1:6] !== AW'(7) || obs_vec[20][VW-1:6] !== AW'(8)) begin
      errors++;
      $display("FAIL jump_self: got %0d,%0d expected 7,8", obs_vec[16][VW-1:6], obs_vec[20][VW-1:6]);
    end
  endtask

  task automatic test_wait();
    int exec_at, fetch_at, n_exec, n_hold;
    do_reset();
    clear_prog(); add_ins(1'b1, 1'b0, AW'(3)); rnd_mode = 1'b0;
    for (int k = 10; k < 15; k++) h_arr[k] = 1'b1;
    build(24); play(24);
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL wait_trace cycle %0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
      end
    end
    exec_at = -1; fetch_at = -1; n_exec = 0; n_hold = 0;
    for (int k = 1; k < 24; k++) begin
      if (fetch_at < 0 && obs_vec[k][3] === 1'b1) fetch_at = k;
    end
    for (int k = 0; k < 16 + HS_LAT; k++) begin
      if (obs_vec[k][2] === 1'b1) begin
        n_exec++;
        if (exec_at < 0) exec_at = k;
      end
      if (obs_vec[k][0] === 1'b1) n_hold++;
    end
    checks++;
    if (exec_at != 11 + HS_LAT) begin
      errors++;
      $display("FAIL wait_exec_entry: got cycle %0d expected %0d", exec_at, 11 + HS_LAT);
    end
    checks++;
    if (n_exec != 1) begin
      errors++;
      $display("FAIL wait_exec_count: got %0d expected 1", n_exec);
    end
    checks++;
    if (n_hold != 12 + HS_LAT) begin
      errors++;
      $display("FAIL wait_hold_cycles: got %0d expected %0d", n_hold, 12 + HS_LAT);
    end
    checks++;
    if (fetch_at != 16 + HS_LAT) begin
      errors++;
      $display("FAIL wait_next_fetch: got cycle %0d expected %0d", fetch_at, 16 + HS_LAT);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [VW-1:0] got;
    do_reset();
    clear_prog();
    add_ins(1'b0, 1'b1, AW'(5));
    add_ins(1'b1, 1'b0, AW'(0));
    rnd_mode = 1'b0;
    build(8); play(8);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL abort_trace cycle %0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
      end
    end
    #2 nReset = 1'b0;
    #1 got = {Addr, Stage, FetchEn, ExecEn, WbEn, PCHold};
    checks++;
    if (got !== RESET_VEC) begin
      errors++;
      $display("FAIL abort_immediate: got %h expected %h", got, RESET_VEC);
    end
    Handshake = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      got = {Addr, Stage, FetchEn, ExecEn, WbEn, PCHold};
      checks++;
      if (got !== RESET_VEC) begin
        errors++;
        $display("FAIL abort_held %0d: got %h expected %h", k, got, RESET_VEC);
      end
    end
    Handshake = 1'b0;
    @(posedge Clock);
    #1 nReset = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    got = {Addr, Stage, FetchEn, ExecEn, WbEn, PCHold};
    checks++;
    if (got !== {AW'(0), 2'd1, 4'b0000}) begin
      errors++;
      $display("FAIL abort_restart: got %h expected %h", got, {AW'(0), 2'd1, 4'b0000});
    end
  endtask

  task automatic test_random();
    int n;
    bit lvl;
    n = 700;
    do_reset();
    clear_prog();
    for (int i = 0; i < 40; i++)
      add_ins(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), AW'($urandom_range(0, LAST)));
    lvl = 1'b0;
    for (int k = 0; k < MAXC; ) begin
      int run;
      run = $urandom_range(1, 6);
      for (int r = 0; r < run && k < MAXC; r++) begin
        h_arr[k] = lvl;
        k++;
      end
      lvl = !lvl;
    end
    rnd_mode = 1'b1;
    build(n); play(n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs_vec[k] !== exp_vec[k]) begin
        errors++;
        $display("FAIL rand_trace cycle %0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequence();
    test_wrap();
    test_jump();
    test_wait();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pico_sequencer.md
PICO_SEQUENCER -- requirements
Module: pico_sequencer

Interface
REQ-001 Parameter ADDR_W, default 5, program-memory address width.
REQ-002 Parameter LAST_ADDR, default 31, highest executed address; must be less than 2**ADDR_W.
REQ-003 Clock  input  1  single system clock; all state on rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 Handshake  input  1  external operator handshake switch, asynchronous to Clock.
REQ-006 WaitReq  input  1  decoded "wait for handshake" flag of the current instruction.
REQ-007 Jump  input  1  decoded branch flag of the current instruction.
REQ-008 JumpAddr  input  ADDR_W  branch target of the current instruction.
REQ-009 Addr  output  ADDR_W  program-memory fetch address, registered.
REQ-010 Stage  output  2  current stage code: FETCH=0, DECODE=1, EXEC=2, WB=3.
REQ-011 FetchEn  output  1  high only in FETCH.
REQ-012 ExecEn  output  1  high only in EXEC; drives accumulator write enable.
REQ-013 WbEn  output  1  high only in WB; drives register-file write qualifier.
REQ-014 PCHold  output  1  high only in WAIT_ASSERT and WAIT_RELEASE.

Function
REQ-015 The FSM SHALL have states FETCH, DECODE, EXEC, WB, WAIT_ASSERT, WAIT_RELEASE; all outputs except Addr are decoded from the state register only (Moore).
REQ-016 FETCH SHALL go to DECODE unconditionally.
REQ-017 DECODE SHALL latch WaitReq, Jump and JumpAddr into internal registers, then go to WAIT_ASSERT if WaitReq=1, else EXEC.
REQ-018 WAIT_ASSERT SHALL hold until the handshake sample hs=1, then go to EXEC.
REQ-019 EXEC SHALL go to WB unconditionally; ExecEn is high for exactly one cycle per instruction.
REQ-020 WB SHALL go to WAIT_RELEASE if the latched wait flag is 1, else to FETCH with an address update.
REQ-021 WAIT_RELEASE SHALL hold until hs=0, then go to FETCH with an address update.
REQ-022 Address update: Addr becomes latched JumpAddr if the latched jump flag is 1; else 0 if Addr==LAST_ADDR; else Addr+1. Addr changes on no other transition.
REQ-023 Stage SHALL read 2 in WAIT_ASSERT and WAIT_RELEASE.
REQ-024 A non-wait instruction SHALL take exactly 4 cycles; a wait instruction takes 4 cycles plus its WAIT_ASSERT and WAIT_RELEASE dwell.
REQ-025 A jump to the current address SHALL be legal: Addr is unchanged and the instruction re-executes.
REQ-026 Handshake already high on entry to WAIT_ASSERT SHALL let WAIT_ASSERT exit after one cycle, given the sampling latency of REQ-033.
REQ-027 Changes on WaitReq, Jump or JumpAddr outside DECODE SHALL have no effect.

Reset
REQ-028 On nReset low, the block SHALL asynchronously enter FETCH, set Addr=0, clear the latched flags, latched JumpAddr and synchroniser flops, and set the outputs to Stage=0, FetchEn=1, ExecEn=0, WbEn=0, PCHold=0.
REQ-029 Reset asserted in any state, including WAIT states, SHALL abort the instruction with no further ExecEn or WbEn pulse.
REQ-030 After nReset deasserts, the first rising edge SHALL move FETCH to DECODE at Addr=0.

Configuration
REQ-031 Macro PICO_SEQ_SYNC_EN selects how Handshake is sampled.
REQ-032 Without the macro, hs SHALL be Handshake sampled directly by the FSM (zero added latency).
REQ-033 With the macro, hs SHALL be the output of a two-flop synchroniser on Handshake, adding 2 cycles of latency to REQ-018 and REQ-021; the ports are unchanged.

Verification
REQ-034 Reset then 12 cycles, WaitReq=0, Jump=0 -> Addr 0,0,0,0,1,1,1,1,2,2,2,2; Stage cycles 0,1,2,3; ExecEn high once per 4 cycles.
REQ-035 LAST_ADDR=3, no jumps -> Addr wraps 3 to 0 on the WB-to-FETCH edge.
REQ-036 At Addr=2, Jump=1 with JumpAddr=7 in DECODE, JumpAddr changed to 9 in EXEC -> next FETCH at Addr=7.
REQ-037 WaitReq=1, Handshake low for 10 cycles then high for 5 then low -> PCHold high through both WAIT states, ExecEn once after the rise, next FETCH only after the fall; Addr held throughout.
REQ-038 nReset pulsed low during WAIT_ASSERT at Addr=5 -> immediate Stage=0, Addr=0, PCHold=0, no ExecEn.
REQ-039 PICO_SEQ_SYNC_EN defined, Handshake rises in WAIT_ASSERT -> EXEC entered exactly 2 cycles later than in the build without the macro.
